// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction fetch
// (read-only) and the data side (load/store). One transaction is outstanding at a
// time. Data wins ties, but a saturating streak counter hands the port to fetch
// after MAX_D_STREAK consecutive data grants made while fetch was waiting.
// A fetch can be flushed mid-flight; the memory transaction still completes and
// only its if_ack is suppressed.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   if_req/if_addr/if_flush     fetch request, address, discard-in-flight
//   if_ack/if_rdata             fetch completion (combinational from m_ack), data
//   d_req/d_we/d_addr/d_wdata/d_be  data request payload
//   d_ack/d_rdata               data completion (combinational from m_ack), data
//   m_req/m_we/m_addr/m_wdata/m_be  registered memory request
//   m_ack/m_rdata               memory completion pulse and read data
//   busy                        a transaction is in flight
module mem_port_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_flush,
    output logic            if_ack,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic            m_ack,
    input  logic [DW-1:0]   m_rdata,
    output logic            busy
);

    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic          discard;

    // Grant decision for the IDLE cycle; a flushing fetch is not eligible
    logic if_ok;
    logic streak_full;
    logic grant_d;
    logic grant_if;

    assign if_ok       = if_req && !if_flush;
    assign streak_full = (streak == SW'(MAX_D_STREAK));
    assign grant_d     = d_req && !(if_ok && streak_full);
    assign grant_if    = if_ok && !grant_d;

    // Completion strobes follow m_ack in the same cycle
    assign d_ack    = (state == BUSY_D) && m_ack;
    assign if_ack   = (state == BUSY_IF) && m_ack && !discard && !if_flush;
    assign d_rdata  = m_rdata;
    assign if_rdata = m_rdata;
    assign busy     = (state != IDLE);

    // Arbiter FSM with registered memory-side request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_be    <= '0;
            streak  <= '0;
            discard <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    discard <= 1'b0;
                    if (grant_d) begin
                        state   <= BUSY_D;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        m_be    <= d_be;
                        // Count only grants that made a waiting fetch lose
                        if (!if_req) begin
                            streak <= '0;
                        end else if (!streak_full) begin
                            streak <= streak + SW'(1);
                        end
                    end else if (grant_if) begin
                        state   <= BUSY_IF;
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= if_addr;
                        m_wdata <= '0;
                        m_be    <= '1;
                        streak  <= '0;
                    end
                end
                BUSY_IF: begin
                    if (m_ack) begin
                        state   <= IDLE;
                        m_req   <= 1'b0;
                        discard <= 1'b0;
                    end else if (if_flush) begin
                        discard <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (m_ack) begin
                        state <= IDLE;
                        m_req <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
